// File: rtl/vram_rect_fill.sv
// Rectangle-fill engine that writes one pixel per clock into VRAM at {y, x}.
// Optional power-up framebuffer clear: define CLEAR_ON_RESET_EN.
module vram_rect_fill #(
  parameter int HBITS      = 7,
  parameter int VBITS      = 7,
  parameter int COLOR_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [HBITS-1:0]      cmd_x0,
  input  logic [VBITS-1:0]      cmd_y0,
  input  logic [HBITS-1:0]      cmd_x1,
  input  logic [VBITS-1:0]      cmd_y1,
  input  logic [COLOR_BITS-1:0] cmd_color,
  output logic                  wr_en,
  output logic [VBITS+HBITS-1:0] wr_addr,
  output logic [COLOR_BITS-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int AW = VBITS + HBITS;
  localparam logic [HBITS-1:0] X_ONE = 1;
  localparam logic [VBITS-1:0] Y_ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE,
    CLEAR
  } state_t;

`ifdef CLEAR_ON_RESET_EN
  localparam state_t RST_STATE = CLEAR;
  localparam logic [AW-1:0] A_ONE = 1;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t state;

  logic [HBITS-1:0] xmin;
  logic [HBITS-1:0] xmax;
  logic [VBITS-1:0] ymax;

  logic [HBITS-1:0] x_lo;
  logic [HBITS-1:0] x_hi;
  logic [VBITS-1:0] y_lo;
  logic [VBITS-1:0] y_hi;

  logic [HBITS-1:0] cur_x;
  logic [VBITS-1:0] cur_y;
  logic             row_end;
  logic             last_px;

  assign cmd_ready = (state == IDLE) && reset;

  always_comb begin
    x_lo = cmd_x0;
    x_hi = cmd_x1;
    y_lo = cmd_y0;
    y_hi = cmd_y1;
    if (cmd_x1 < cmd_x0) begin
      x_lo = cmd_x1;
      x_hi = cmd_x0;
    end
    if (cmd_y1 < cmd_y0) begin
      y_lo = cmd_y1;
      y_hi = cmd_y0;
    end
  end

  // The write address doubles as the raster cursor.
  assign cur_x   = wr_addr[HBITS-1:0];
  assign cur_y   = wr_addr[AW-1:HBITS];
  assign row_end = (cur_x == xmax);
  assign last_px = row_end && (cur_y == ymax);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RST_STATE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      xmin    <= '0;
      xmax    <= '0;
      ymax    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            state   <= FILL;
            xmin    <= x_lo;
            xmax    <= x_hi;
            ymax    <= y_hi;
            wr_en   <= 1'b1;
            wr_addr <= {y_lo, x_lo};
            wr_data <= cmd_color;
            busy    <= 1'b1;
          end
        end
        FILL: begin
          if (last_px) begin
            wr_en <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (row_end) begin
            wr_addr <= {cur_y + Y_ONE, xmin};
          end else begin
            wr_addr[HBITS-1:0] <= cur_x + X_ONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        CLEAR: begin
`ifdef CLEAR_ON_RESET_EN
          if (!wr_en) begin
            wr_en   <= 1'b1;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b1;
          end else if (&wr_addr) begin
            wr_en <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wr_addr <= wr_addr + A_ONE;
          end
`else
          state <= IDLE;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_rect_fill.sv
// Directed and randomized bench for vram_rect_fill.
// Expected raster addresses are derived arithmetically from pixel index.
module tb_vram_rect_fill;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_x0;
  logic [6:0]  cmd_y0;
  logic [6:0]  cmd_x1;
  logic [6:0]  cmd_y1;
  logic [2:0]  cmd_color;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [2:0]  wr_data;
  logic        busy;
  logic        done;

  int n_assert;
  int n_fail;

  vram_rect_fill dut (
    .clk       (clk),
    .reset     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int x0, input int y0, input int x1,
                       input int y1, input int c);
    cmd_valid = 1'b1;
    cmd_x0    = 7'(x0);
    cmd_y0    = 7'(y0);
    cmd_x1    = 7'(x1);
    cmd_y1    = 7'(y1);
    cmd_color = 3'(c);
  endtask

  // Entered at the negedge of the first write cycle; leaves at the
  // negedge of the first idle cycle after done.
  task automatic expect_fill(input string tag, input int x0, input int y0,
                             input int x1, input int y1, input int c);
    int xl, xh, yl, yh, w, h, p, errs, ea, last;
    xl = (x0 < x1) ? x0 : x1;
    xh = (x0 < x1) ? x1 : x0;
    yl = (y0 < y1) ? y0 : y1;
    yh = (y0 < y1) ? y1 : y0;
    w = xh - xl + 1;
    h = yh - yl + 1;
    p = w * h;
    errs = 0;
    last = yh * 128 + xh;
    for (int k = 0; k < p; k++) begin
      ea = (yl + k / w) * 128 + (xl + k % w);
      if (k == 0)
        check({tag, " first_addr"}, 32'(wr_addr), 32'(ea));
      if (k == p - 1)
        check({tag, " last_addr"}, 32'(wr_addr), 32'(ea));
      if (wr_en !== 1'b1 || wr_addr !== 14'(ea) || wr_data !== 3'(c) ||
          busy !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b0)
        errs++;
      @(negedge clk);
    end
    check({tag, " pixel_errs"}, 32'(errs), 32'd0);
    check({tag, " done_pulse"}, 32'(done), 32'd1);
    check({tag, " done_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, " done_busy"}, 32'(busy), 32'd1);
    check({tag, " done_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, " hold_addr"}, 32'(wr_addr), 32'(last));
    check({tag, " hold_data"}, 32'(wr_data), 32'(c));
    @(negedge clk);
    check({tag, " post_done"}, 32'(done), 32'd0);
    check({tag, " post_busy"}, 32'(busy), 32'd0);
    check({tag, " post_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, " post_wr_en"}, 32'(wr_en), 32'd0);
  endtask

  task automatic run_cmd(input string tag, input int x0, input int y0,
                         input int x1, input int y1, input int c);
    drive(x0, y0, x1, y1, c);
    check({tag, " ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    expect_fill(tag, x0, y0, x1, y1, c);
  endtask

  initial begin
    int errs;
    int rx0, ry0, rx1, ry1, rc;
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_x0    = '0;
    cmd_y0    = '0;
    cmd_x1    = '0;
    cmd_y1    = '0;
    cmd_color = '0;
    repeat (3) @(negedge clk);
    check("rst wr_en", 32'(wr_en), 32'd0);
    check("rst wr_addr", 32'(wr_addr), 32'd0);
    check("rst wr_data", 32'(wr_data), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst ready", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    run_cmd("single", 5, 9, 5, 9, 3'b101);
    run_cmd("swapped", 10, 3, 8, 2, 3'b010);
    run_cmd("edge_row", 127, 0, 120, 3, 3'b111);
    run_cmd("corner", 127, 127, 127, 127, 3'b001);
    run_cmd("full", 0, 0, 127, 127, 3'b110);

    drive(1, 1, 3, 2, 3'b011);
    @(posedge clk);
    @(negedge clk);
    drive(40, 50, 38, 50, 3'b100);
    expect_fill("b2b_a", 1, 1, 3, 2, 3'b011);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    expect_fill("b2b_b", 40, 50, 38, 50, 3'b100);
    errs = 0;
    repeat (4) begin
      if (wr_en !== 1'b0 || busy !== 1'b0) errs++;
      @(negedge clk);
    end
    check("b2b no_dup", 32'(errs), 32'd0);

    for (int i = 0; i < 8; i++) begin
      rx0 = $urandom_range(0, 127);
      ry0 = $urandom_range(0, 127);
      rx1 = rx0 ^ $urandom_range(0, 7);
      ry1 = ry0 ^ $urandom_range(0, 7);
      rc  = $urandom_range(0, 7);
      run_cmd($sformatf("rand%0d", i), rx0, ry0, rx1, ry1, rc);
    end

    drive(0, 0, 7, 7, 3'b011);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid 3rd_wr_en", 32'(wr_en), 32'd1);
    check("mid 3rd_addr", 32'(wr_addr), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst_wr_en", 32'(wr_en), 32'd0);
    check("mid rst_busy", 32'(busy), 32'd0);
    check("mid rst_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    repeat (6) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
          cmd_ready !== 1'b1)
        errs++;
    end
    check("mid post_idle", 32'(errs), 32'd0);

    run_cmd("after_rst", 2, 2, 3, 3, 3'b101);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
